// File: rtl/mem_stage.sv
// Memory-access stage: latches the execute bus, captures SRAM read data,
// extends loads by byte offset and forwards results to write-back/bypass.
module mem_stage (
    input  logic        clk,
    input  logic        resetn,
    input  logic        es_to_ms_valid,
    input  logic [75:0] es_to_ms_bus,
    output logic        ms_allowin,
    input  logic [31:0] data_sram_rdata,
    input  logic        ws_allowin,
    output logic        ms_to_ws_valid,
    output logic [69:0] ms_to_ws_bus,
    output logic [38:0] ms_rf_collect
);

    logic        ms_valid_q, ms_valid_d;
    logic [75:0] bus_q, bus_d;
    logic        first_q, first_d;
    logic [31:0] rdata_buf_q, rdata_buf_d;

    logic        ms_ready_go;
    logic        accept;

    logic [4:0]  ld_op;
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
    logic [31:0] pc;

    logic [1:0]  off;
    logic [31:0] mem_rdata;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] load_result;
    logic [31:0] final_result;

    assign ms_ready_go    = 1'b1;
    assign ms_allowin     = ~ms_valid_q | (ms_ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid_q & ms_ready_go;
    assign accept         = es_to_ms_valid & ms_allowin;

    assign {ld_op, res_from_mem, rf_we, rf_waddr, alu_result, pc} = bus_q;

    always_comb begin
        ms_valid_d  = ms_valid_q;
        bus_d       = bus_q;
        first_d     = accept;
        rdata_buf_d = rdata_buf_q;
        if (ms_allowin) begin
            ms_valid_d = es_to_ms_valid;
        end
        if (accept) begin
            bus_d = es_to_ms_bus;
        end
        // SRAM output is only trustworthy the cycle after the request.
        if (first_q) begin
            rdata_buf_d = data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            ms_valid_q  <= 1'b0;
            bus_q       <= '0;
            first_q     <= 1'b0;
            rdata_buf_q <= '0;
        end else begin
            ms_valid_q  <= ms_valid_d;
            bus_q       <= bus_d;
            first_q     <= first_d;
            rdata_buf_q <= rdata_buf_d;
        end
    end

    assign off       = alu_result[1:0];
    assign mem_rdata = first_q ? data_sram_rdata : rdata_buf_q;

    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (off)
            2'd0: byte_sel = mem_rdata[7:0];
            2'd1: byte_sel = mem_rdata[15:8];
            2'd2: byte_sel = mem_rdata[23:16];
            2'd3: byte_sel = mem_rdata[31:24];
            default: byte_sel = mem_rdata[7:0];
        endcase
    end

    assign half_sel = off[1] ? mem_rdata[31:16] : mem_rdata[15:0];

    always_comb begin
        load_result = mem_rdata;
        unique case (1'b1)
            ld_op[4]: load_result = {{24{byte_sel[7]}}, byte_sel};
            ld_op[3]: load_result = {{16{half_sel[15]}}, half_sel};
            ld_op[2]: load_result = mem_rdata;
            ld_op[1]: load_result = {24'd0, byte_sel};
            ld_op[0]: load_result = {16'd0, half_sel};
            default:  load_result = mem_rdata;
        endcase
    end

    assign final_result = res_from_mem ? load_result : alu_result;

    assign ms_to_ws_bus  = {rf_we, rf_waddr, final_result, pc};
    assign ms_rf_collect = {res_from_mem & ms_valid_q, rf_we & ms_valid_q,
                            rf_waddr, final_result};

endmodule

// File: doc/mem_stage.md
# mem_stage

Memory-access stage of the five-stage in-order pipeline. It sits between the execute stage and the write-back stage. It latches the execute-stage bus and captures the synchronous data-SRAM read data. It then sign- or zero-extends load results by byte offset, and forwards the final result to write-back and to the decode-stage bypass/interlock logic.

## Interface
Parameters: none.

Ports:
- clk  input  1  pipeline clock
- resetn  input  1  reset: synchronous, active-low
- es_to_ms_valid  input  1  execute stage holds a completed instruction
- es_to_ms_bus  input  76  {ld_op[4:0] = {ld_b, ld_h, ld_w, ld_bu, ld_hu}, res_from_mem, rf_we, rf_waddr[4:0], alu_result[31:0], pc[31:0]}, MSB first
- ms_allowin  output  1  stage can accept a new instruction this cycle
- data_sram_rdata  input  32  SRAM read data; valid exactly one cycle after the execute stage's request
- ws_allowin  input  1  write-back stage can accept
- ms_to_ws_valid  output  1  instruction ready for write-back
- ms_to_ws_bus  output  70  {rf_we, rf_waddr[4:0], final_result[31:0], pc[31:0]}
- ms_rf_collect  output  39  {res_from_mem & ms_valid, rf_we & ms_valid, rf_waddr[4:0], final_result[31:0]}; same layout as the execute-stage collect bus

## Operation
- Handshake:
  - ms_ready_go = 1.
  - ms_allowin = ~ms_valid | (ms_ready_go & ws_allowin).
  - ms_to_ws_valid = ms_valid & ms_ready_go.
- ms_valid loads es_to_ms_valid whenever ms_allowin = 1.
- Bus registers load es_to_ms_bus only when es_to_ms_valid & ms_allowin; otherwise they hold.
- Read-data capture: the SRAM output may change while this stage is stalled, because execute re-issues requests.
  - first_cycle register: set to 1 on every bus load, cleared on the next cycle.
  - On a first_cycle, mem_rdata = data_sram_rdata, and rdata_buf <= data_sram_rdata.
  - On later cycles, mem_rdata = rdata_buf.
- Load extraction, with off = alu_result[1:0]:
  - ld_b / ld_bu: byte off, i.e. bits [8·off+7 : 8·off]; sign- or zero-extended to 32 bits.
  - ld_h / ld_hu: off[1]=0 selects [15:0], off[1]=1 selects [31:16]; sign- or zero-extended. off[0] is ignored.
  - ld_w: full word; offset ignored.
  - res_from_mem=1 with ld_op=0 is treated as ld_w.
- final_result = res_from_mem ? load_result : alu_result.
- ms_to_ws_bus fields pass through from the latched bus. rf_we is not gated in ms_to_ws_bus; write-back gates it with its own valid.
- ms_rf_collect gates rf_we and res_from_mem with ms_valid, so the decode stage never sees a stale write target.

## Timing
- Reset, synchronous; in the cycle after resetn is sampled low:
  - ms_valid = 0, first_cycle = 0, all bus registers = 0, rdata_buf = 0.
  - Outputs: ms_allowin = 1, ms_to_ws_valid = 0, ms_rf_collect = 0, ms_to_ws_bus = 0.
- Latency: 1 cycle per instruction with no stall. A load issued in execute at cycle N is latched at the edge ending N. Its extended result is on ms_to_ws_bus and ms_rf_collect during cycle N+1.
- Stall (ws_allowin = 0): all state holds; the result stays stable for the whole stall, whatever data_sram_rdata does after the first cycle.
- Simultaneous accept and retire (ms_valid = 1, ws_allowin = 1, es_to_ms_valid = 1): the new instruction replaces the old one in the same edge, and first_cycle is set again.
- Bubble (es_to_ms_valid = 0 while ms_allowin = 1): ms_valid drops to 0 and the bus registers hold stale values. Collect gating masks them.
- Reset mid-stall: reset wins; the in-flight instruction is discarded.

## Test plan
- ld_b, alu_result = 0x1000_0003, rdata = 0x80xx_xxxx → final_result = 0xFFFF_FF80. Same case with ld_bu → 0x0000_0080.
- ld_h at offset 2, rdata = 0x8001_1234 → 0xFFFF_8001. ld_hu at offset 0 → 0x0000_1234.
- Load latched, ws_allowin held 0 for 3 cycles, data_sram_rdata changed to 0xDEAD_BEEF after the first cycle → final_result still reflects the first-cycle data; ms_allowin = 0 throughout.
- Back-to-back ALU ops (res_from_mem = 0, alu_result 0x11 then 0x22) with ws_allowin = 1 → ms_to_ws_valid is 1 on consecutive cycles, with results 0x11 then 0x22 and matching pc.
- Bubble after a write (rf_we = 1, waddr = 5) → the next cycle's ms_rf_collect[37] = 0 and ms_to_ws_valid = 0.
- resetn low while valid and stalled → the next cycle has ms_valid = 0, ms_allowin = 1, and ms_rf_collect = 0.
